vector_reg_apply: RTL and testbench
===================================

# vector_reg_apply

Consumer stage for a configuration vector arriving from a clock-domain-crossing register. It qualifies each new vector value for a fixed number of consecutive enabled cycles, holds the qualified value pending, and commits it to its output only at a safe point signalled by `apply_strobe_i` (e.g. a vsync or frame-start pulse). It also emits a one-cycle update pulse, so downstream video logic never sees a configuration change mid-frame or a transient intermediate value.

## Interface
- `reg_width`, 16, width of the configuration vector
- `reg_preset`, `{reg_width{1'b0}}`, reset value of the committed and candidate vectors
- `stable_cycles`, 4, consecutive enabled cycles a new value must persist before it becomes pending; legal range 1..255
- `timeout_cycles`, 1024, enabled cycles spent pending before a forced commit; legal range 1..65535; used only with `VECTOR_REG_APPLY_TIMEOUT_EN`

- `clk_i`  in  1  clock; the single clock of the block
- `rst_i`  in  1  reset; synchronous, active-high
- `clk_en_i`  in  1  clock enable; state advances only when high
- `vecreg_i`  in  reg_width  synchronized vector from the CDC stage
- `apply_strobe_i`  in  1  safe-point strobe, sampled only when `clk_en_i`=1
- `vecreg_o`  out  reg_width  committed vector (registered)
- `pending_o`  out  1  high while a qualified value awaits commit
- `update_o`  out  1  one `clk_i`-cycle pulse in the cycle `vecreg_o` takes a new value

## Operation
- **Reset** (`rst_i`=1 at a `clk_i` edge, regardless of `clk_en_i`):
  - `vecreg_o`=`reg_preset`; `cand`=`reg_preset`; `update_o`=0; `pending_o`=0.
  - Stability counter=0; timeout counter=0; state=IDLE.
  - Reset mid-operation discards any candidate or pending value.
- **Enable gating:** with `clk_en_i`=0, all state, counters and `vecreg_o` hold. `update_o` still clears on the next `clk_i` edge, so it is never longer than one `clk_i` cycle.
- **State machine** (evaluated on enabled edges only):
  - **IDLE**
    - If `vecreg_i`≠`vecreg_o`: `cand`←`vecreg_i`, cnt←1, go to QUALIFY.
    - If `stable_cycles`=1, go directly to PENDING instead.
  - **QUALIFY**
    - If `vecreg_i`=`vecreg_o`: go to IDLE (the change was withdrawn).
    - Else if `vecreg_i`≠`cand`: `cand`←`vecreg_i`, cnt←1 (restart qualification).
    - Else cnt←cnt+1; when cnt+1 = `stable_cycles`, go to PENDING.
    - `apply_strobe_i` is ignored in this state and is not remembered.
  - **PENDING**
    - `pending_o`=1.
    - Input change has priority over the strobe:
      - `vecreg_i`=`vecreg_o`: go to IDLE.
      - `vecreg_i`≠`cand` (and ≠`vecreg_o`): `cand`←`vecreg_i`, cnt←1, go to QUALIFY.
    - Else, if `apply_strobe_i`=1: `vecreg_o`←`cand`, `update_o`←1, go to IDLE.
- **Counter width:** the stability counter is `$clog2(stable_cycles+1)` bits and saturates. It never wraps.
- **Flag encoding:** `pending_o` is decoded from the registered state.

## Timing
- Vector changes at enabled edge E0, where it is first sampled:
  - `cand` captured at E0.
  - `pending_o` rises after edge E0+`stable_cycles`−1.
- A strobe sampled high at the first enabled edge with `pending_o`=1 commits at that edge:
  - `vecreg_o` and `update_o` are valid in the following cycle.
  - Minimum change-to-commit latency: `stable_cycles` enabled edges.
- Back-to-back commits are separated by at least `stable_cycles`+1 enabled edges.
- No combinational path from any input to any output.

## Configuration
- **`VECTOR_REG_APPLY_TIMEOUT_EN` defined:**
  - The timeout counter clears on entry to PENDING and increments on each enabled PENDING edge.
  - When it reaches `timeout_cycles` with no strobe, the block commits `cand` exactly as a strobe would: `update_o` pulses and the state returns to IDLE.
  - A strobe and timeout on the same edge produce a single commit.
- **Not defined:**
  - No timeout counter is built.
  - PENDING is held indefinitely until a strobe arrives or the input changes.

## Test plan
- **Reset and idle:** `reg_preset`=16'h00A5; assert `rst_i` for 2 cycles, then hold `vecreg_i`=16'h00A5.
  - Required: `vecreg_o`=16'h00A5, `pending_o`=0 and `update_o`=0 throughout.
- **Basic commit:** `stable_cycles`=4, `clk_en_i`=1; step `vecreg_i` to 16'h1234; strobe 10 cycles later.
  - Required: `pending_o` high from the 4th edge after the change.
  - Required: `vecreg_o`=16'h1234 and a single-cycle `update_o` pulse the cycle after the strobe.
- **Glitch rejection:** `vecreg_i` 16'h1234 for 2 cycles, then 16'h5678 held; strobe every cycle.
  - Required: 16'h1234 is never committed.
  - Required: 16'h5678 commits exactly 4 enabled edges after its first sample.
- **Withdrawal and priority:** while PENDING with `cand`=16'h5678, drive `vecreg_i` back to the committed value in the same cycle as a strobe.
  - Required: no commit, no `update_o` pulse, state returns to IDLE.
- **Enable gating:** toggle `clk_en_i` 1-0-1-0 during qualification.
  - Required: the commit point is counted in enabled edges only.
  - Required: `update_o` stays high for exactly one `clk_i` cycle even when `clk_en_i`=0 follows the commit.
- **Timeout:** `VECTOR_REG_APPLY_TIMEOUT_EN` defined, `timeout_cycles`=8; no strobe.
  - Required: commit 8 enabled edges after `pending_o` rises.
  - Required: with the macro undefined, no commit after 1000 cycles.

Source files
------------

// File: rtl/vector_reg_apply.sv
// ----------------------------------------------------------------------------
// vector_reg_apply
//
// Consumer stage for a configuration vector coming out of a CDC register.
// A new input value must stay steady for stable_cycles enabled cycles. It is
// then held pending, and it is committed only when apply_strobe_i arrives
// (for example a vsync or frame-start pulse). Downstream logic therefore never
// sees a configuration change mid-frame or a transient intermediate value.
//
// Optional feature (macro VECTOR_REG_APPLY_TIMEOUT_EN):
//   When defined, a pending value is force-committed after timeout_cycles
//   enabled cycles with no strobe. When undefined, no timeout logic is built.
//
// Parameters:
//   reg_width       width of the configuration vector
//   reg_preset      reset value of the committed and candidate vectors
//   stable_cycles   enabled cycles a new value must persist (1..255)
//   timeout_cycles  enabled pending cycles before a forced commit (1..65535)
//
// Ports:
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   clk_en_i        clock enable; state advances only when high
//   vecreg_i        synchronized vector from the CDC stage
//   apply_strobe_i  safe-point strobe, sampled only on enabled edges
//   vecreg_o        committed vector (registered)
//   pending_o       high while a qualified value awaits commit
//   update_o        one-clk_i-cycle pulse when vecreg_o takes a new value
// ----------------------------------------------------------------------------
module vector_reg_apply #(
    parameter int unsigned          reg_width      = 16,
    parameter logic [reg_width-1:0] reg_preset     = '0,
    parameter int unsigned          stable_cycles  = 4,
    parameter int unsigned          timeout_cycles = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clk_en_i,
    input  logic [reg_width-1:0] vecreg_i,
    input  logic                 apply_strobe_i,
    output logic [reg_width-1:0] vecreg_o,
    output logic                 pending_o,
    output logic                 update_o
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StQualify = 2'd1;
    localparam logic [1:0] StPending = 2'd2;

    localparam int unsigned   CntW   = $clog2(stable_cycles + 1);
    localparam logic [CntW-1:0] CntSat = '1;

    // Elaboration-time check of the parameter ranges
    if (stable_cycles < 1 || stable_cycles > 255 ||
        timeout_cycles < 1 || timeout_cycles > 65535) begin : g_bad_param
        $error("vector_reg_apply: stable_cycles or timeout_cycles out of range");
    end

    logic [1:0]           state_q, state_d;
    logic [reg_width-1:0] cand_q, cand_d;
    logic [reg_width-1:0] vec_q, vec_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 update_q;
    logic                 commit;
    logic                 timeout_hit;

`ifdef VECTOR_REG_APPLY_TIMEOUT_EN
    localparam int unsigned   TcntW   = $clog2(timeout_cycles + 1);
    localparam logic [TcntW-1:0] TcntSat = '1;

    logic [TcntW-1:0] tcnt_q, tcnt_d;

    // Held at zero outside PENDING, so it is clear on every entry to PENDING.
    // The hit fires on the edge where this PENDING edge is the timeout_cycles-th.
    assign timeout_hit = (state_q == StPending) &&
                         ((32'(tcnt_q) + 32'd1) >= timeout_cycles);

    always_comb begin
        tcnt_d = '0;
        if (state_q == StPending && tcnt_q != TcntSat) begin
            tcnt_d = tcnt_q + 1'b1;
        end else if (state_q == StPending) begin
            tcnt_d = tcnt_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tcnt_q <= '0;
        end else if (clk_en_i) begin
            tcnt_q <= tcnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        commit  = 1'b0;
        case (state_q)
            StIdle: begin
                if (vecreg_i != vec_q) begin
                    cand_d  = vecreg_i;
                    cnt_d   = CntW'(1);
                    state_d = (stable_cycles == 1) ? StPending : StQualify;
                end
            end
            StQualify: begin
                if (vecreg_i == vec_q) begin
                    state_d = StIdle;
                end else if (vecreg_i != cand_q) begin
                    cand_d = vecreg_i;
                    cnt_d  = CntW'(1);
                end else begin
                    if (cnt_q != CntSat) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    // >= also covers stable_cycles == 1 after a restart from PENDING
                    if ((32'(cnt_q) + 32'd1) >= stable_cycles) begin
                        state_d = StPending;
                    end
                end
            end
            StPending: begin
                // An input change outranks both the strobe and the timeout
                if (vecreg_i == vec_q) begin
                    state_d = StIdle;
                end else if (vecreg_i != cand_q) begin
                    cand_d  = vecreg_i;
                    cnt_d   = CntW'(1);
                    state_d = StQualify;
                end else if (apply_strobe_i || timeout_hit) begin
                    commit  = 1'b1;
                    vec_d   = cand_q;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cand_q   <= reg_preset;
            vec_q    <= reg_preset;
            cnt_q    <= '0;
            update_q <= 1'b0;
        end else begin
            // Pulse clears on every clk_i edge so it never outlasts one cycle
            update_q <= 1'b0;
            if (clk_en_i) begin
                state_q  <= state_d;
                cand_q   <= cand_d;
                vec_q    <= vec_d;
                cnt_q    <= cnt_d;
                update_q <= commit;
            end
        end
    end

    assign vecreg_o  = vec_q;
    assign pending_o = (state_q == StPending);
    assign update_o  = update_q;

endmodule

// File: tb/tb_vector_reg_apply.sv
module tb_vector_reg_apply;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic [15:0] vin;
    logic        strobe;
    logic [15:0] vout;
    logic        pend;
    logic        upd;

    int n_vec = 0;
    int n_err = 0;
    logic seen_upd;

    vector_reg_apply #(
        .reg_width     (16),
        .reg_preset    (16'h00A5),
        .stable_cycles (4),
        .timeout_cycles(8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clk_en_i      (clk_en),
        .vecreg_i      (vin),
        .apply_strobe_i(strobe),
        .vecreg_o      (vout),
        .pending_o     (pend),
        .update_o      (upd)
    );

    always #5 clk = ~clk;

    // One clock edge; outputs are sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [15:0] v, input logic p,
                              input logic u);
        check({tag, ".vec"}, vout, v);
        check({tag, ".pend"}, {15'd0, pend}, {15'd0, p});
        check({tag, ".upd"}, {15'd0, upd}, {15'd0, u});
    endtask

    initial begin
        // Reset and idle
        rst = 1'b1; clk_en = 1'b1; vin = 16'h00A5; strobe = 1'b0;
        tick(); tick();
        expect_out("reset", 16'h00A5, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("idle%0d", i), 16'h00A5, 1'b0, 1'b0);
        end

        // Basic commit: pending after the 4th edge, strobe on the 10th
        vin = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("basic_q%0d", i), 16'h00A5, 1'b0, 1'b0);
        end
        tick();
        expect_out("basic_pend", 16'h00A5, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out($sformatf("basic_wait%0d", i), 16'h00A5, 1'b1, 1'b0);
        end
        strobe = 1'b1;
        tick();
        expect_out("basic_commit", 16'h1234, 1'b0, 1'b1);
        strobe = 1'b0;
        tick();
        expect_out("basic_after", 16'h1234, 1'b0, 1'b0);

        // Glitch rejection: reset back to preset, 1234 for 2 cycles, then 5678
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out("glitch_reset", 16'h00A5, 1'b0, 1'b0);
        strobe = 1'b1;
        vin = 16'h1234;
        tick();
        expect_out("glitch_a0", 16'h00A5, 1'b0, 1'b0);
        tick();
        expect_out("glitch_a1", 16'h00A5, 1'b0, 1'b0);
        vin = 16'h5678;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("glitch_b%0d", i), 16'h00A5, 1'b0, 1'b0);
        end
        tick();
        expect_out("glitch_pend", 16'h00A5, 1'b1, 1'b0);
        tick();
        expect_out("glitch_commit", 16'h5678, 1'b0, 1'b1);
        strobe = 1'b0;
        tick();
        expect_out("glitch_after", 16'h5678, 1'b0, 1'b0);

        // Withdrawal beats a same-cycle strobe
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vin = 16'h5678;
        tick(); tick(); tick(); tick();
        expect_out("wd_pend", 16'h00A5, 1'b1, 1'b0);
        vin = 16'h00A5;
        strobe = 1'b1;
        tick();
        expect_out("wd_strobe", 16'h00A5, 1'b0, 1'b0);
        strobe = 1'b0;
        tick();
        expect_out("wd_idle", 16'h00A5, 1'b0, 1'b0);

        // Enable gating: only enabled edges count
        vin = 16'hBEEF;
        clk_en = 1'b1; tick(); expect_out("en_e1", 16'h00A5, 1'b0, 1'b0);
        clk_en = 1'b0; tick(); expect_out("en_d1", 16'h00A5, 1'b0, 1'b0);
        clk_en = 1'b1; tick(); expect_out("en_e2", 16'h00A5, 1'b0, 1'b0);
        clk_en = 1'b0; tick(); expect_out("en_d2", 16'h00A5, 1'b0, 1'b0);
        clk_en = 1'b1; tick(); expect_out("en_e3", 16'h00A5, 1'b0, 1'b0);
        tick(); expect_out("en_e4", 16'h00A5, 1'b1, 1'b0);
        clk_en = 1'b0; tick(); expect_out("en_hold", 16'h00A5, 1'b1, 1'b0);
        strobe = 1'b1;
        tick(); expect_out("en_strobe_gated", 16'h00A5, 1'b1, 1'b0);
        clk_en = 1'b1;
        tick(); expect_out("en_commit", 16'hBEEF, 1'b0, 1'b1);
        clk_en = 1'b0; strobe = 1'b0;
        tick(); expect_out("en_pulse_end", 16'hBEEF, 1'b0, 1'b0);

        // Timeout
        clk_en = 1'b1;
        vin = 16'hCAFE;
        tick(); tick(); tick(); tick();
        expect_out("to_pend", 16'hBEEF, 1'b1, 1'b0);
`ifdef VECTOR_REG_APPLY_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            expect_out($sformatf("to_wait%0d", i), 16'hBEEF, 1'b1, 1'b0);
        end
        tick();
        expect_out("to_commit", 16'hCAFE, 1'b0, 1'b1);
        tick();
        expect_out("to_after", 16'hCAFE, 1'b0, 1'b0);
`else
        seen_upd = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (upd) seen_upd = 1'b1;
        end
        check("noto_upd_seen", {15'd0, seen_upd}, 16'd0);
        expect_out("noto_hold", 16'hBEEF, 1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
